// File: rtl/spi_ram_pkg.sv
// Shared opcodes, frame geometry and FSM encoding for the SPI RAM master.
package spi_ram_pkg;

    localparam int FRAME_W = 10;
    localparam int DATA_W  = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        WAIT,
        RECV,
        END
    } state_t;

endpackage

// File: rtl/spi_shifter.sv
// Shift register with parallel load, MSB serial out and LSB serial in.
module spi_shifter
    import spi_ram_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift_en,
    input  logic         sin,
    output logic         sout,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift_en) begin
            q <= {q[W-2:0], sin};
        end
    end

    assign sout = q[W-1];

endmodule

// File: rtl/spi_ram_master.sv
// SPI master that serialises {op, data} frames to the RAM slave wrapper and
// returns the byte read back on op 11 frames.
//
// state | meaning
// IDLE  | ready for a request, SS_n high
// START | SS_n low, MOSI 0 for one cycle
// SHIFT | frame bits 9..0 on MOSI
// WAIT  | RD_LAT cycles of slave read latency (op 11 only)
// RECV  | 8 MISO bits shifted in, MSB first
// END   | GAP cycles with SS_n high before returning to IDLE
module spi_ram_master
    import spi_ram_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int GAP    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] RECV_LOAD  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               is_read;
    logic               accept;
    logic               rsp_fire;

    logic               tx_sout;
    logic [FRAME_W-1:0] tx_q;
    logic               rx_sout;
    logic [DATA_W-1:0]  rx_q;
    logic               unused_bits;

    spi_shifter #(.W(FRAME_W)) u_tx (
        .clk       (clk),
        .rst       (rst),
        .load      (accept),
        .load_data ({req_op, req_data}),
        .shift_en  (state_nxt == SHIFT),
        .sin       (1'b0),
        .sout      (tx_sout),
        .q         (tx_q)
    );

    spi_shifter #(.W(DATA_W)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .load_data ('0),
        .shift_en  (state == RECV),
        .sin       (MISO),
        .sout      (rx_sout),
        .q         (rx_q)
    );

    assign unused_bits = ^{tx_q, rx_sout, rx_q[DATA_W-1]};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        rsp_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept    = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                state_nxt = SHIFT;
                cnt_nxt   = SHIFT_LOAD;
            end
            SHIFT: begin
                if (cnt == '0) begin
                    state_nxt = is_read ? WAIT : END;
                    cnt_nxt   = is_read ? LAT_LOAD : GAP_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RECV;
                    cnt_nxt   = RECV_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            RECV: begin
                if (cnt == '0) begin
                    state_nxt = END;
                    cnt_nxt   = GAP_LOAD;
                    rsp_fire  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            END: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so pins line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            is_read   <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            if (accept) begin
                is_read <= (req_op == OP_RD_DATA);
            end
            SS_n      <= !(state_nxt inside {START, SHIFT, WAIT, RECV});
            MOSI      <= (state_nxt == SHIFT) ? tx_sout : 1'b0;
            busy      <= (state_nxt != IDLE);
            req_ready <= (state_nxt == IDLE);
            rsp_valid <= rsp_fire;
            if (rsp_fire) begin
                rsp_data <= {rx_q[DATA_W-2:0], MISO};
            end
        end
    end

endmodule
